// File: rtl/pe_result_collector_if.sv
// Signal bundle between a CGRA PE lane, its result collector and the AXI4-Stream sink.
// The stat_beats/stat_pkts signals exist only when PE_COLLECTOR_STATS_EN is defined.
interface pe_result_collector_if #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DWIDTH-1:0] in_tdata;
  logic              in_tvalid;
  logic              issue_fire;
  logic              issue_ok;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_keep_last;
  logic [DWIDTH-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              overflow;
  logic [OCC_W-1:0]  occupancy;

  // master is the surrounding lane (PE, operand issuer, stream sink); slave is the collector
`ifdef PE_COLLECTOR_STATS_EN
  logic [31:0] stat_beats;
  logic [31:0] stat_pkts;

  modport master (
    output in_tdata, in_tvalid, issue_fire, cfg_len, cfg_keep_last, m_axis_tready,
    input  issue_ok, m_axis_tdata, m_axis_tvalid, m_axis_tlast, overflow, occupancy,
    input  stat_beats, stat_pkts
  );
  modport slave (
    input  in_tdata, in_tvalid, issue_fire, cfg_len, cfg_keep_last, m_axis_tready,
    output issue_ok, m_axis_tdata, m_axis_tvalid, m_axis_tlast, overflow, occupancy,
    output stat_beats, stat_pkts
  );
`else
  modport master (
    output in_tdata, in_tvalid, issue_fire, cfg_len, cfg_keep_last, m_axis_tready,
    input  issue_ok, m_axis_tdata, m_axis_tvalid, m_axis_tlast, overflow, occupancy
  );
  modport slave (
    input  in_tdata, in_tvalid, issue_fire, cfg_len, cfg_keep_last, m_axis_tready,
    output issue_ok, m_axis_tdata, m_axis_tvalid, m_axis_tlast, overflow, occupancy
  );
`endif
endinterface

// File: rtl/pe_result_collector.sv
// Drain end of a CGRA PE lane: buffers the un-throttled result stream, re-emits it as AXI4-Stream
// and issues operand credits. Define PE_COLLECTOR_STATS_EN to add output handshake/packet counters.
module pe_result_collector #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 32,
  parameter int PE_LAT = 16,
  parameter int LEN_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  pe_result_collector_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int IN_W  = $clog2(DEPTH + PE_LAT + 1) + 1;
  localparam int HW    = IN_W + 2;

  logic [DWIDTH:0]   mem_q [DEPTH];
  logic [DWIDTH:0]   headWord;
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [LEN_W-1:0]  beatCnt_q, beatCnt_d;
  logic [LEN_W-1:0]  lastIdx;
  logic [IN_W-1:0]   inflight_q, inflight_d, inflightInc;
  logic              overflow_q, overflow_d;
  logic [HW-1:0]     headroom;
  logic              isLast, empty, full, pushReq, push, pop;

  // Keep-last mode only commits the closing beat; its sum already holds the whole packet.
  always_comb begin
    lastIdx     = (bus.cfg_len == '0) ? '0 : bus.cfg_len - LEN_W'(1);
    isLast      = (beatCnt_q == lastIdx);
    empty       = (occ_q == '0);
    full        = (occ_q == OCC_W'(DEPTH));
    pop         = !empty && bus.m_axis_tready;
    pushReq     = bus.in_tvalid && (!bus.cfg_keep_last || isLast);
    push        = pushReq && (!full || pop);

    beatCnt_d   = beatCnt_q;
    if (bus.in_tvalid) begin
      beatCnt_d = isLast ? '0 : beatCnt_q + LEN_W'(1);
    end

    wrPtr_d     = push ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d     = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
    occ_d       = occ_q + OCC_W'(push) - OCC_W'(pop);
    overflow_d  = overflow_q || (pushReq && full && !pop);

    inflightInc = inflight_q + IN_W'(bus.issue_fire);
    inflight_d  = (bus.in_tvalid && inflightInc != '0) ? inflightInc - IN_W'(1) : inflightInc;

    headroom    = HW'(DEPTH) - HW'(occ_q) - HW'(inflight_q) - HW'(bus.issue_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      occ_q      <= '0;
      beatCnt_q  <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      occ_q      <= occ_d;
      beatCnt_q  <= beatCnt_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {isLast, bus.in_tdata};
    end
  end

  assign headWord          = mem_q[rdPtr_q];
  assign bus.m_axis_tvalid = !empty;
  assign bus.m_axis_tdata  = empty ? '0 : headWord[DWIDTH-1:0];
  assign bus.m_axis_tlast  = !empty && headWord[DWIDTH];
  assign bus.overflow      = overflow_q;
  assign bus.occupancy     = occ_q;
  assign bus.issue_ok      = !headroom[HW-1] && (headroom != '0);

`ifdef PE_COLLECTOR_STATS_EN
  logic [31:0] statBeats_q, statPkts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statBeats_q <= '0;
      statPkts_q  <= '0;
    end else if (pop) begin
      statBeats_q <= statBeats_q + 32'd1;
      statPkts_q  <= statPkts_q + 32'(headWord[DWIDTH]);
    end
  end

  assign bus.stat_beats = statBeats_q;
  assign bus.stat_pkts  = statPkts_q;
`endif
endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector: stimulus pushes expected beats, a monitor pops and
// compares every output handshake.
module tb_pe_result_collector;
  localparam int DWIDTH = 64;
  localparam int DEPTH  = 32;
  localparam int PE_LAT = 16;
  localparam int LEN_W  = 16;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  int                errors = 0;
  int                checks = 0;
  int                popCount = 0;
  beat_t             expQ[$];
  beat_t             monBeat;
  int                issued, maxOcc, seq, popsBefore;
  logic              canIssue, resultNow;
  logic [PE_LAT-1:0] pipe;
  logic [63:0]       t1Data [4];

  always #5 clk = ~clk;

  pe_result_collector_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  pe_result_collector #(
    .DWIDTH(DWIDTH), .DEPTH(DEPTH), .PE_LAT(PE_LAT), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one input cycle; a beat that should reach the output is queued at the same moment.
  task automatic applyStimulus(input logic valid, input logic [63:0] data,
                               input logic expectOut, input logic expLast);
    @(posedge clk); #1;
    bus.in_tvalid = valid;
    bus.in_tdata  = data;
    if (valid && expectOut) expQ.push_back('{data: data, last: expLast});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_tvalid"},    64'(bus.m_axis_tvalid), 64'd0);
    checkOutput({tag, "_tlast"},     64'(bus.m_axis_tlast),  64'd0);
    checkOutput({tag, "_tdata"},     bus.m_axis_tdata,       64'd0);
    checkOutput({tag, "_occupancy"}, 64'(bus.occupancy),     64'd0);
    checkOutput({tag, "_overflow"},  64'(bus.overflow),      64'd0);
    checkOutput({tag, "_issue_ok"},  64'(bus.issue_ok),      64'd1);
  endtask

  // Monitor: every accepted output beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
      popCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got data %0h last %0b, expected no beat",
                 bus.m_axis_tdata, bus.m_axis_tlast);
      end else begin
        monBeat = expQ.pop_front();
        checkOutput("beat_data", bus.m_axis_tdata, monBeat.data);
        checkOutput("beat_last", 64'(bus.m_axis_tlast), 64'(monBeat.last));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    bus.in_tdata      = '0;
    bus.in_tvalid     = 1'b0;
    bus.issue_fire    = 1'b0;
    bus.cfg_len       = 16'd4;
    bus.cfg_keep_last = 1'b0;
    bus.m_axis_tready = 1'b0;
    t1Data[0] = $realtobits(1.0);
    t1Data[1] = $realtobits(2.0);
    t1Data[2] = $realtobits(3.0);
    t1Data[3] = $realtobits(4.0);
    #12;
    checkResetState("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: streaming packet of four, one cycle latency, tlast on the fourth
    $display("[TB] T1 stream mode");
    bus.m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, t1Data[k], 1'b1, k == 3);
      @(negedge clk);
      checkOutput("t1_occ_pipelined", 64'(bus.occupancy), (k == 0) ? 64'd0 : 64'd1);
    end
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_last_visible", 64'(bus.m_axis_tvalid), 64'd1);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_drained", 64'(expQ.size()), 64'd0);

    // T2: keep-last, packets of three, only the closing beats appear
    $display("[TB] T2 keep-last mode");
    bus.cfg_len       = 16'd3;
    bus.cfg_keep_last = 1'b1;
    popsBefore = popCount;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 64'(k), (k % 3) == 0, 1'b1);
    end
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t2_beat_count", 64'(popCount - popsBefore), 64'd2);
    checkOutput("t2_queue_empty", 64'(expQ.size()), 64'd0);

    // T3: credit-limited fill with tready low; length 0 behaves as length 1
    $display("[TB] T3 credit fill");
    @(posedge clk); #1;
    bus.cfg_len       = 16'd0;
    bus.cfg_keep_last = 1'b0;
    bus.m_axis_tready = 1'b0;
    issued = 0;
    maxOcc = 0;
    seq    = 0;
    pipe   = '0;
    @(negedge clk);
    canIssue = bus.issue_ok;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      bus.issue_fire = canIssue;
      if (canIssue) issued++;
      resultNow = pipe[PE_LAT-1];
      pipe = {pipe[PE_LAT-2:0], canIssue};
      bus.in_tvalid = resultNow;
      bus.in_tdata  = 64'h100 + 64'(seq);
      if (resultNow) begin
        expQ.push_back('{data: 64'h100 + 64'(seq), last: 1'b1});
        seq++;
      end
      @(negedge clk);
      canIssue = bus.issue_ok;
      if (int'(bus.occupancy) > maxOcc) maxOcc = int'(bus.occupancy);
    end
    @(posedge clk); #1;
    bus.issue_fire = 1'b0;
    bus.in_tvalid  = 1'b0;
    @(negedge clk);
    checkOutput("t3_issued", 64'(issued), 64'(DEPTH));
    checkOutput("t3_peak_occ", 64'(maxOcc), 64'(DEPTH));
    checkOutput("t3_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("t3_issue_ok_low", 64'(bus.issue_ok), 64'd0);

    // T5: simultaneous push and pop on a full FIFO
    $display("[TB] T5 full push+pop");
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b1;
    bus.in_tvalid     = 1'b1;
    bus.in_tdata      = 64'h5000;
    expQ.push_back('{data: 64'h5000, last: 1'b1});
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b0;
    bus.in_tvalid     = 1'b0;
    @(negedge clk);
    checkOutput("t5_occ", 64'(bus.occupancy), 64'(DEPTH));
    checkOutput("t5_overflow", 64'(bus.overflow), 64'd0);

    // T4: push into a full FIFO without a pop is dropped and latches overflow
    $display("[TB] T4 overflow then drain");
    applyStimulus(1'b1, 64'hDEAD, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4_overflow", 64'(bus.overflow), 64'd1);
    checkOutput("t4_occ", 64'(bus.occupancy), 64'(DEPTH));
    popsBefore = popCount;
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.m_axis_tvalid !== 1'b1) break;
    end
    checkOutput("t4_drain_count", 64'(popCount - popsBefore), 64'(DEPTH));
    checkOutput("t4_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("t4_overflow_sticky", 64'(bus.overflow), 64'd1);

    // T6: reset in the middle of a packet discards it and restarts beat counting
    $display("[TB] T6 reset mid-packet");
    @(posedge clk); #1;
    bus.m_axis_tready = 1'b0;
    bus.cfg_len       = 16'd4;
    applyStimulus(1'b1, 64'd11, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'd12, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    rst = 1'b1;
    expQ.delete();
    #1;
    checkResetState("t6_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_axis_tready = 1'b1;
    popsBefore = popCount;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 64'(20 + k), 1'b1, k == 4);
    end
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_beat_count", 64'(popCount - popsBefore), 64'd4);
    checkOutput("t6_queue_empty", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
